shifter_bist: RTL and testbench
===============================

# shifter_bist

Synthesizable built-in self-test initiator for the 4-bit barrel shifter. It drives every combination of `data`/`shift`/`dir` into the shifter once, in a fixed order, and samples the returned `result` after a configurable latency. Each result is checked against an internal reference model, and the block reports a pass/fail verdict, an error count and the first failing vector. It sits on the shifter's driving side, standing in for the write driver on silicon and in bring-up benches.

## Interface
- `DUT_LAT`, default 1: register stages between shifter inputs and `result` (0 = combinational).
- `ROTATE`, default 0: reference model mode; 0 = logical shift with zero fill, 1 = rotate.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: level, sampled in IDLE or DONE; launches a run.
- `busy` output 1: high while vectors are driven or results are pending.
- `done` output 1: high in DONE, held until the next accepted `start` or reset.
- `pass` output 1: valid while `done`=1; 1 when `err_count`==0.
- `err_count` output 8: number of mismatching vectors in the last run (maximum 128).
- `first_fail_vec` output 7: index of the first mismatching vector; 0 if none.
- `data_o` output 4: shifter `data`, registered.
- `shift_o` output 2: shifter `shift`, registered.
- `dir_o` output 1: shifter `dir`, registered; 1 = left, 0 = right.
- `result_i` input 4: shifter `result`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`=1. Clears `err_count`, `first_fail_vec` and the fail-seen flag.
  - RUN: 7-bit index `i` counts 0 to 127, one vector per cycle. Vector mapping: `data_o`=`i[3:0]`, `shift_o`=`i[5:4]`, `dir_o`=`i[6]`. RUN → DRAIN after `i`=127 is launched.
  - DRAIN: drive outputs are 0; waits for the remaining DUT_LAT+1 compares. DRAIN → DONE on the last compare.
  - DONE → RUN on `start`=1. This clears all results and `done` in the same edge.
- `start` is ignored in RUN and DRAIN.
- Drive outputs are 0 in IDLE, DRAIN and DONE.
- Reference model, with `d`=data and `s`=shift:
  - Left: `(d << s) & 4'hF`.
  - Right: `d >> s`.
  - ROTATE=1: circular rotate in the given direction.
- Expected pipeline: DUT_LAT+1 stages, each holding {valid, expected[3:0], index[6:0]}.
  - Filled at each launch.
  - Compared against `result_i` when the last stage is valid.
- On mismatch:
  - `err_count` increments.
  - If the fail-seen flag is clear, `first_fail_vec` takes the index and the flag is set.
- `err_count` cannot exceed 128, so no saturation logic is needed.
- `pass` = `done` & (`err_count`==0). It is 0 outside DONE.
- Asynchronous reset, at any time including mid-run:
  - State returns to IDLE.
  - All outputs go to 0.
  - The pipeline's valid bits are cleared.
  - No further compares occur.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_vec`=0, `data_o`=0, `shift_o`=0, `dir_o`=0.
- `start` is sampled at edge S.
  - Vector `i` appears on the drive outputs after edge S+i.
  - `busy` rises after S.
- The result for vector `i` is sampled at edge S+i+DUT_LAT+1.
- Drive outputs return to 0 after edge S+128.
- The last compare is at S+128+DUT_LAT. At that edge:
  - `busy` falls.
  - `done` rises.
  - The final `err_count`/`pass` are visible in the same cycle.
- `busy` is high for exactly 128+DUT_LAT cycles.
- `start` held high through DONE restarts on the first DONE cycle's edge, so `done` pulses for one cycle.

## Test plan
- Ideal registered shifter, DUT_LAT=1, ROTATE=0, single `start` pulse:
  - `busy` is high for 129 cycles.
  - Then `done`=1, `pass`=1, `err_count`=0, `first_fail_vec`=0.
  - Drive outputs walk indices 0 to 127 in order.
- Same setup with `result_i[0]` stuck at 0:
  - `err_count`=40 (32 right-shift plus 8 left-shift vectors with expected bit 0 = 1).
  - `first_fail_vec`=1, `pass`=0.
- Ideal rotating shifter with ROTATE=1, then a logical-shift DUT with ROTATE=1:
  - Rotating DUT: first run passes.
  - Logical-shift DUT: mismatches wherever shifted-out bits are nonzero.
  - `first_fail_vec`=2 (data=2, shift=0? no: first rotate-right mismatch is `i`=17, data=1, shift=1), so the bench checks `first_fail_vec`=17.
- Latency mismatch, combinational DUT with DUT_LAT=1:
  - Results are compared one vector late.
  - `pass`=0, `err_count`>0.
- `start` asserted continuously during RUN, then reset asserted mid-run at index 50:
  - `start` has no effect while busy.
  - On reset, all outputs go to 0 immediately, with no compare after reset.
  - A new `start` after reset release gives a full 128-vector run and `pass`=1.
- Back-to-back runs: pulse `start` in DONE after a failing run.
  - Counters clear at the accepting edge.
  - A second run with the ideal DUT gives `err_count`=0, `pass`=1.

Source files
------------

// File: rtl/shifter_bist.sv
`default_nettype none
// ============================================================================
// shifter_bist : exhaustive self-test initiator/checker for a 4-bit barrel
//                shifter. Rev 1.0
// ============================================================================
module shifter_bist #(
  parameter int DUT_LAT = 1,
  parameter bit ROTATE  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [6:0] first_fail_vec,
  output logic [3:0] data_o,
  output logic [1:0] shift_o,
  output logic       dir_o,
  input  logic [3:0] result_i
);

  localparam int NSTG = DUT_LAT + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [6:0]           idx_q;
  logic                 fail_seen_q;
  logic [NSTG-1:0]      pv_q;
  logic [NSTG-1:0][3:0] pexp_q;
  logic [NSTG-1:0][6:0] pidx_q;

  logic       accept;
  logic       launch;
  logic [6:0] lidx;
  logic       cmp;
  logic       mism;
  logic       last;
  logic [7:0] err_d;

  // Vector index packs as {dir, shift[1:0], data[3:0]}.
  function automatic logic [3:0] ref_model(input logic [6:0] v);
    logic [7:0] dd;
    logic [7:0] l;
    logic [7:0] r;
    dd = {v[3:0], v[3:0]};
    l  = dd << v[5:4];
    r  = dd >> v[5:4];
    if (ROTATE) begin
      return v[6] ? l[7:4] : r[3:0];
    end
    return v[6] ? (v[3:0] << v[5:4]) : (v[3:0] >> v[5:4]);
  endfunction

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign launch = accept || (state_q == S_RUN);
  assign lidx   = (state_q == S_RUN) ? idx_q : 7'd0;
  assign cmp    = pv_q[NSTG-1];
  assign mism   = cmp && (result_i != pexp_q[NSTG-1]);
  assign last   = cmp && (pidx_q[NSTG-1] == 7'd127);
  assign err_d  = err_count + {7'd0, mism};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= 7'd0;
      fail_seen_q    <= 1'b0;
      pv_q           <= '0;
      pexp_q         <= '0;
      pidx_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 8'd0;
      first_fail_vec <= 7'd0;
      data_o         <= 4'd0;
      shift_o        <= 2'd0;
      dir_o          <= 1'b0;
    end else begin
      // Expected-value pipeline tracks the shifter's latency plus our drive register.
      pv_q[0]   <= launch;
      pexp_q[0] <= ref_model(lidx);
      pidx_q[0] <= lidx;
      for (int k = 1; k < NSTG; k++) begin
        pv_q[k]   <= pv_q[k-1];
        pexp_q[k] <= pexp_q[k-1];
        pidx_q[k] <= pidx_q[k-1];
      end

      {dir_o, shift_o, data_o} <= launch ? lidx : 7'd0;

      if (mism) begin
        err_count <= err_d;
        if (!fail_seen_q) begin
          first_fail_vec <= pidx_q[NSTG-1];
          fail_seen_q    <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q        <= S_RUN;
            idx_q          <= 7'd1;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 8'd0;
            first_fail_vec <= 7'd0;
            fail_seen_q    <= 1'b0;
          end
        end
        S_RUN: begin
          idx_q <= idx_q + 7'd1;
          if (idx_q == 7'd127) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last) begin
            state_q <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_d == 8'd0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shifter_bist.sv
`default_nettype none
// tb_shifter_bist : directed bench; three BIST instances each drive a behavioural
// shifter whose latency, mode and faults the stimulus selects.
module tb_shifter_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st    [3];
  logic       bsy   [3];
  logic       dn    [3];
  logic       ps    [3];
  logic [7:0] ec    [3];
  logic [6:0] ff    [3];
  logic [3:0] dat   [3];
  logic [1:0] sh    [3];
  logic       dr    [3];
  logic [3:0] res   [3];
  logic [3:0] cres  [3];
  logic [3:0] rres  [3];
  bit         m_comb  [3];
  bit         m_rot   [3];
  bit         m_stuck [3];

  int n_chk;
  int n_fail;
  int cyc;

  shifter_bist #(.DUT_LAT(1), .ROTATE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]),
    .err_count(ec[0]), .first_fail_vec(ff[0]), .data_o(dat[0]), .shift_o(sh[0]),
    .dir_o(dr[0]), .result_i(res[0]));

  shifter_bist #(.DUT_LAT(1), .ROTATE(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]),
    .err_count(ec[1]), .first_fail_vec(ff[1]), .data_o(dat[1]), .shift_o(sh[1]),
    .dir_o(dr[1]), .result_i(res[1]));

  shifter_bist #(.DUT_LAT(0), .ROTATE(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .busy(bsy[2]), .done(dn[2]), .pass(ps[2]),
    .err_count(ec[2]), .first_fail_vec(ff[2]), .data_o(dat[2]), .shift_o(sh[2]),
    .dir_o(dr[2]), .result_i(res[2]));

  function automatic logic [3:0] shf(input logic [3:0] d, input logic [1:0] s,
                                     input logic dir, input bit rot);
    logic [7:0] x;
    logic [3:0] y;
    if (rot) begin
      x = {d, d};
      if (dir) begin x = x << s; y = x[7:4]; end
      else     begin x = x >> s; y = x[3:0]; end
    end else begin
      y = dir ? (d << s) : (d >> s);
    end
    return y;
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cres[k] = shf(dat[k], sh[k], dr[k], m_rot[k]) & (m_stuck[k] ? 4'hE : 4'hF);
      res[k]  = m_comb[k] ? cres[k] : rres[k];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) rres[k] <= cres[k];
  end

  function automatic logic [6:0] vec(input int k);
    return {dr[k], sh[k], dat[k]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One start pulse, then follow the run until busy drops (bounded).
  task automatic do_run(input int k, input int lat, input bit walk);
    int c;
    @(negedge clk); st[k] = 1'b1;
    @(posedge clk); #1; st[k] = 1'b0;
    check_eq("accept_busy", bsy[k], 1);
    check_eq("accept_done", dn[k], 0);
    check_eq("accept_pass", ps[k], 0);
    check_eq("accept_err", ec[k], 0);
    check_eq("accept_ffv", ff[k], 0);
    c = 0;
    while (bsy[k] && c < 400) begin
      if (walk && c < 128) check_eq("walk_idx", vec(k), c);
      if (walk && c == 128) check_eq("drain_zero", vec(k), 0);
      @(posedge clk); #1; c++;
    end
    check_eq("busy_len", c, 128 + lat);
    check_eq("done_rise", dn[k], 1);
    check_eq("end_drive_zero", vec(k), 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; m_comb[k] = 1'b0; m_rot[k] = 1'b0; m_stuck[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", bsy[0], 0);
    check_eq("rst_done", dn[0], 0);
    check_eq("rst_pass", ps[0], 0);
    check_eq("rst_err", ec[0], 0);
    check_eq("rst_ffv", ff[0], 0);
    check_eq("rst_drive", vec(0), 0);
    @(negedge clk); rst_n = 1'b1;

    // Ideal registered logical shifter.
    do_run(0, 1, 1'b1);
    check_eq("ideal_pass", ps[0], 1);
    check_eq("ideal_err", ec[0], 0);
    check_eq("ideal_ffv", ff[0], 0);

    // result bit 0 stuck at 0.
    m_stuck[0] = 1'b1;
    do_run(0, 1, 1'b0);
    check_eq("stuck_err", ec[0], 40);
    check_eq("stuck_ffv", ff[0], 1);
    check_eq("stuck_pass", ps[0], 0);

    // Back-to-back restart from a failing DONE.
    m_stuck[0] = 1'b0;
    do_run(0, 1, 1'b0);
    check_eq("b2b_pass", ps[0], 1);
    check_eq("b2b_err", ec[0], 0);

    // Combinational shifter against DUT_LAT=1.
    m_comb[0] = 1'b1;
    do_run(0, 1, 1'b0);
    check_eq("lat_pass", ps[0], 0);
    check_eq("lat_err_nz", (ec[0] != 8'd0), 1);
    check_eq("lat_ffv", ff[0], 0);
    m_comb[0] = 1'b0;

    // Rotate reference: rotating DUT, then logical DUT.
    m_rot[1] = 1'b1;
    do_run(1, 1, 1'b0);
    check_eq("rot_pass", ps[1], 1);
    check_eq("rot_err", ec[1], 0);
    m_rot[1] = 1'b0;
    do_run(1, 1, 1'b0);
    check_eq("rotlog_err", ec[1], 68);
    check_eq("rotlog_ffv", ff[1], 17);
    check_eq("rotlog_pass", ps[1], 0);

    // Zero-latency configuration.
    m_comb[2] = 1'b1;
    do_run(2, 0, 1'b1);
    check_eq("lat0_pass", ps[2], 1);
    m_stuck[2] = 1'b1;
    do_run(2, 0, 1'b0);
    check_eq("lat0_stuck_err", ec[2], 40);
    check_eq("lat0_stuck_ffv", ff[2], 1);
    m_stuck[2] = 1'b0;

    // start held through DONE: one-cycle done pulse, immediate restart.
    @(negedge clk); st[2] = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (bsy[2] && cyc < 400) begin @(posedge clk); #1; cyc++; end
    check_eq("hold_busy_len", cyc, 128);
    check_eq("hold_done", dn[2], 1);
    check_eq("hold_pass", ps[2], 1);
    @(posedge clk); #1;
    check_eq("hold_restart_done", dn[2], 0);
    check_eq("hold_restart_busy", bsy[2], 1);
    st[2] = 1'b0;
    cyc = 0;
    while (bsy[2] && cyc < 400) begin @(posedge clk); #1; cyc++; end
    check_eq("hold_second_len", cyc, 128);
    check_eq("hold_second_pass", ps[2], 1);

    // start held during RUN, then asynchronous reset at index 50.
    m_stuck[0] = 1'b1;
    @(negedge clk); st[0] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 50; i++) begin
      check_eq("held_walk", vec(0), i);
      @(posedge clk); #1;
    end
    check_eq("held_idx50", vec(0), 50);
    check_eq("held_busy", bsy[0], 1);
    check_eq("held_err50", ec[0], 24);
    check_eq("held_ffv50", ff[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", bsy[0], 0);
    check_eq("mid_rst_done", dn[0], 0);
    check_eq("mid_rst_pass", ps[0], 0);
    check_eq("mid_rst_err", ec[0], 0);
    check_eq("mid_rst_ffv", ff[0], 0);
    check_eq("mid_rst_drive", vec(0), 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hold_err", ec[0], 0);
    st[0] = 1'b0;
    m_stuck[0] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_busy", bsy[0], 0);
    check_eq("post_rst_err", ec[0], 0);
    do_run(0, 1, 1'b1);
    check_eq("post_rst_pass", ps[0], 1);
    check_eq("post_rst_err_end", ec[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
